// File: rtl/lns_addsub_pipe.sv
// lns_addsub_pipe: three-stage pipelined LNS add/subtract unit.
// Each word is {sign, log}. The log is a LOG_W-bit two's-complement log2 magnitude
// with FRAC_W fractional bits. The most negative log (MINL) encodes zero.
// The pipeline stalls globally: every stage advances only when the output
// register is empty or being drained.
//
// Optional feature: define LNS_SAT_CNT_EN to add a 16-bit saturating count of
// transferred results that overflowed (port sat_cnt).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_op 0 = x+y, 1 = x-y
//   in_x, in_y          operands {sign, log}
//   out_valid/out_ready result handshake
//   out_z               result {sign, log}
//   out_ovf             result clamped to MAXL
//   out_zero            result is the canonical zero
//   sat_cnt             (LNS_SAT_CNT_EN only) saturating overflow count

// lns_phi: Gaussian-log correction term, combinational.
//   i_sub = 0 : sb(-d) = log2(1 + 2^-d)
//   i_sub = 1 : db(-d) = log2(1 - 2^-d), d > 0
// Piecewise-linear interpolation over Q16 tables at integer d. Segment [0,1)
// of db is sampled every 1/8 because of its pole at 0.
// Valid for 4 <= FRAC_W <= 15.
module lns_phi #(
  parameter int unsigned LOG_W  = 11,
  parameter int unsigned FRAC_W = 5
) (
  input  logic                    i_sub,
  input  logic [LOG_W:0]          i_d,
  output logic signed [LOG_W:0]   o_phi
);

  localparam int unsigned W = LOG_W + 1;

  // log2(1 + 2^-k) in Q16
  function automatic int sb_q16(input int k);
    case (k)
      0:  sb_q16 = 65536;
      1:  sb_q16 = 38336;
      2:  sb_q16 = 21098;
      3:  sb_q16 = 11136;
      4:  sb_q16 = 5732;
      5:  sb_q16 = 2909;
      6:  sb_q16 = 1466;
      7:  sb_q16 = 736;
      8:  sb_q16 = 369;
      9:  sb_q16 = 184;
      10: sb_q16 = 92;
      11: sb_q16 = 46;
      12: sb_q16 = 23;
      13: sb_q16 = 12;
      14: sb_q16 = 6;
      15: sb_q16 = 3;
      default: sb_q16 = 0;
    endcase
  endfunction

  // log2(1 - 2^-k) in Q16, k >= 1
  function automatic int db_q16(input int k);
    case (k)
      1:  db_q16 = -65536;
      2:  db_q16 = -27200;
      3:  db_q16 = -12625;
      4:  db_q16 = -6102;
      5:  db_q16 = -3002;
      6:  db_q16 = -1489;
      7:  db_q16 = -742;
      8:  db_q16 = -370;
      9:  db_q16 = -185;
      10: db_q16 = -92;
      11: db_q16 = -46;
      12: db_q16 = -23;
      13: db_q16 = -12;
      14: db_q16 = -6;
      15: db_q16 = -3;
      default: db_q16 = 0;
    endcase
  endfunction

  // log2(1 - 2^-(j/8)) in Q16; j = 0 is a finite stand-in for the pole
  function automatic int db0_q16(input int j);
    case (j)
      0: db0_q16 = -393216;
      1: db0_q16 = -235327;
      2: db0_q16 = -173801;
      3: db0_q16 = -139410;
      4: db0_q16 = -116100;
      5: db0_q16 = -98832;
      6: db0_q16 = -85367;
      7: db0_q16 = -74506;
      default: db0_q16 = -65536;
    endcase
  endfunction

  function automatic logic [LOG_W:0] phi_f(input logic sub, input logic [LOG_W:0] d);
    int k, f, j, rem, bits, a, b, v, q;
    k = int'(d) >> FRAC_W;
    f = int'(d) & ((1 << FRAC_W) - 1);
    if (k >= 16) begin
      phi_f = '0;
    end else begin
      if (sub && (k == 0)) begin
        j    = f >> (FRAC_W - 3);
        rem  = f & ((1 << (FRAC_W - 3)) - 1);
        bits = int'(FRAC_W) - 3;
        a    = db0_q16(j);
        b    = db0_q16(j + 1);
      end else begin
        rem  = f;
        bits = int'(FRAC_W);
        a    = sub ? db_q16(k)     : sb_q16(k);
        b    = sub ? db_q16(k + 1) : sb_q16(k + 1);
      end
      v = a + (((b - a) * rem) >>> bits);
      // Round Q16 to FRAC_W fractional bits
      q = (v + (1 << (15 - FRAC_W))) >>> (16 - FRAC_W);
      phi_f = W'(q);
    end
  endfunction

  assign o_phi = phi_f(i_sub, i_d);

endmodule

module lns_addsub_pipe #(
  parameter int unsigned LOG_W  = 11,
  parameter int unsigned FRAC_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [LOG_W:0]   in_x,
  input  logic [LOG_W:0]   in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_W:0]   out_z,
  output logic             out_ovf,
  output logic             out_zero
`ifdef LNS_SAT_CNT_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam logic [LOG_W-1:0]        MAXL  = {1'b0, {(LOG_W-1){1'b1}}};
  localparam logic [LOG_W-1:0]        MINL  = {1'b1, {(LOG_W-1){1'b0}}};
  localparam logic [LOG_W:0]          ZERO  = {1'b0, MINL};
  localparam logic signed [LOG_W:0]   R_MAX = {1'b0, MAXL};
  localparam logic signed [LOG_W:0]   R_MIN = {1'b1, MINL};

  // Global advance: the whole pipe moves when the output slot is free or draining
  logic w_adv;
  logic r3_v;
  assign w_adv    = ~r3_v | out_ready;
  assign in_ready = w_adv;

  // Stage 1 combinational: operand classification and ordering
  logic                    w_xs, w_ys, w_eff_sub, w_x_big, w_zx, w_zy, w_cancel;
  logic [LOG_W-1:0]        w_xl, w_yl;
  logic signed [LOG_W:0]   w_xe, w_ye;
  logic [LOG_W:0]          w_d;

  assign w_xs      = in_x[LOG_W];
  assign w_xl      = in_x[LOG_W-1:0];
  assign w_ys      = in_y[LOG_W] ^ in_op;
  assign w_yl      = in_y[LOG_W-1:0];
  assign w_eff_sub = w_xs ^ w_ys;
  assign w_x_big   = $signed(w_xl) >= $signed(w_yl);
  assign w_xe      = {w_xl[LOG_W-1], w_xl};
  assign w_ye      = {w_yl[LOG_W-1], w_yl};
  assign w_d       = w_x_big ? (w_xe - w_ye) : (w_ye - w_xe);
  assign w_zx      = (w_xl == MINL);
  assign w_zy      = (w_yl == MINL);
  assign w_cancel  = (w_xl == w_yl) & w_eff_sub & ~w_zx & ~w_zy;

  logic                    r1_v, r1_sub, r1_sign, r1_zx, r1_zy, r1_cancel;
  logic [LOG_W-1:0]        r1_log;
  logic [LOG_W:0]          r1_d;

  // Stage 2 combinational: correction term
  logic signed [LOG_W:0]   w_phi;

  lns_phi #(.LOG_W(LOG_W), .FRAC_W(FRAC_W)) u_phi (
    .i_sub (r1_sub),
    .i_d   (r1_d),
    .o_phi (w_phi)
  );

  logic                    r2_v, r2_sign, r2_zx, r2_zy, r2_cancel;
  logic [LOG_W-1:0]        r2_log;
  logic signed [LOG_W:0]   r2_phi;

  // Stage 3 combinational: sum and result classification.
  // A zero operand has the minimum log, so the "larger" operand is always the
  // non-zero one when exactly one input is zero.
  logic signed [LOG_W:0]   w_r;
  logic [LOG_W:0]          w_z;
  logic                    w_ovf, w_zero;

  assign w_r = {r2_log[LOG_W-1], r2_log} + r2_phi;

  always_comb begin
    w_z    = {r2_sign, w_r[LOG_W-1:0]};
    w_ovf  = 1'b0;
    w_zero = 1'b0;
    if (r2_zx & r2_zy) begin
      w_z    = ZERO;
      w_zero = 1'b1;
    end else if (r2_zx | r2_zy) begin
      w_z    = {r2_sign, r2_log};
    end else if (r2_cancel) begin
      w_z    = ZERO;
      w_zero = 1'b1;
    end else if (w_r > R_MAX) begin
      w_z    = {r2_sign, MAXL};
      w_ovf  = 1'b1;
    end else if (w_r <= R_MIN) begin
      w_z    = ZERO;
      w_zero = 1'b1;
    end
  end

  logic [LOG_W:0]          r3_z;
  logic                    r3_ovf, r3_zero;

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v      <= 1'b0;
      r1_sub    <= 1'b0;
      r1_sign   <= 1'b0;
      r1_log    <= '0;
      r1_d      <= '0;
      r1_zx     <= 1'b0;
      r1_zy     <= 1'b0;
      r1_cancel <= 1'b0;
      r2_v      <= 1'b0;
      r2_sign   <= 1'b0;
      r2_log    <= '0;
      r2_phi    <= '0;
      r2_zx     <= 1'b0;
      r2_zy     <= 1'b0;
      r2_cancel <= 1'b0;
      r3_v      <= 1'b0;
      r3_z      <= ZERO;
      r3_ovf    <= 1'b0;
      r3_zero   <= 1'b0;
    end else if (w_adv) begin
      r1_v      <= in_valid;
      r1_sub    <= w_eff_sub;
      r1_sign   <= w_x_big ? w_xs : w_ys;
      r1_log    <= w_x_big ? w_xl : w_yl;
      r1_d      <= w_d;
      r1_zx     <= w_zx;
      r1_zy     <= w_zy;
      r1_cancel <= w_cancel;
      r2_v      <= r1_v;
      r2_sign   <= r1_sign;
      r2_log    <= r1_log;
      r2_phi    <= w_phi;
      r2_zx     <= r1_zx;
      r2_zy     <= r1_zy;
      r2_cancel <= r1_cancel;
      r3_v      <= r2_v;
      r3_z      <= w_z;
      r3_ovf    <= w_ovf;
      r3_zero   <= w_zero;
    end
  end

  assign out_valid = r3_v;
  assign out_z     = r3_z;
  assign out_ovf   = r3_ovf;
  assign out_zero  = r3_zero;

`ifdef LNS_SAT_CNT_EN
  // Sticky-at-max count of overflowed results actually handed downstream
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (r3_v & out_ready & r3_ovf & (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_lns_addsub_pipe.sv
// Directed bench for lns_addsub_pipe (LOG_W=11, FRAC_W=5) with a result scoreboard.
module tb_lns_addsub_pipe;

  localparam int unsigned LOG_W  = 11;
  localparam int unsigned FRAC_W = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [11:0] in_x;
  logic [11:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_z;
  logic        out_ovf;
  logic        out_zero;
`ifdef LNS_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  lns_addsub_pipe #(.LOG_W(LOG_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
`ifdef LNS_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  typedef struct packed {
    logic [11:0] z;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          errors  = 0;
  int          checks  = 0;
  int          exp_sat = 0;
  int          popped  = 0;
  logic [11:0] hold_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transferred result is compared in order
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("z[%0d]", popped), 32'(out_z), 32'(mon_e.z));
        chk($sformatf("ovf[%0d]", popped), 32'(out_ovf), 32'(mon_e.ovf));
        chk($sformatf("zero[%0d]", popped), 32'(out_zero), 32'(mon_e.zero));
        if (mon_e.ovf) exp_sat++;
        popped++;
      end
    end
  end

  // Present one operand pair and wait (bounded) for acceptance
  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic op,
                      input logic [11:0] ez, input logic eo, input logic ezr, input bit push);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_op    = op;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sb_q.push_back(exp_t'{z: ez, ovf: eo, zero: ezr});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_z", 32'(out_z), 32'h400);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1 + 1 = 2 with latency check
    send(12'h000, 12'h000, 1'b0, 12'h020, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("lat1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat3", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back directed vectors
    send(12'h000, 12'h000, 1'b1, 12'h400, 1'b0, 1'b1, 1'b1); // exact cancel
    send(12'h000, 12'h800, 1'b0, 12'h400, 1'b0, 1'b1, 1'b1); // cancel via signs
    send(12'h3FF, 12'h3FF, 1'b0, 12'h3FF, 1'b1, 1'b0, 1'b1); // overflow clamp
    send(12'h400, 12'h0A0, 1'b1, 12'h8A0, 1'b0, 1'b0, 1'b1); // x zero, y negated
    send(12'h8A0, 12'hC00, 1'b0, 12'h8A0, 1'b0, 1'b0, 1'b1); // y zero
    send(12'h040, 12'h020, 1'b1, 12'h020, 1'b0, 1'b0, 1'b1); // 4-2 = 2
    send(12'h040, 12'h020, 1'b0, 12'h053, 1'b0, 1'b0, 1'b1); // 4+2 = 6
    send(12'h020, 12'h040, 1'b1, 12'h820, 1'b0, 1'b0, 1'b1); // 2-4 = -2
    send(12'h401, 12'h402, 1'b1, 12'h400, 1'b0, 1'b1, 1'b1); // underflow
    send(12'h100, 12'h000, 1'b0, 12'h100, 1'b0, 1'b0, 1'b1); // negligible addend
    send(12'h400, 12'hC00, 1'b0, 12'h400, 1'b0, 1'b1, 1'b1); // both zero
    send(12'h3FF, 12'h401, 1'b1, 12'h3FF, 1'b0, 1'b0, 1'b1); // max distance, no ovf
    drain();

    // Stall: 5 back-to-back ops with the output blocked
    out_ready = 1'b0;
    send(12'h040, 12'h020, 1'b1, 12'h020, 1'b0, 1'b0, 1'b1);
    send(12'h020, 12'h040, 1'b1, 12'h820, 1'b0, 1'b0, 1'b1);
    send(12'h100, 12'h000, 1'b0, 12'h100, 1'b0, 1'b0, 1'b1);
    fork
      begin
        send(12'h000, 12'h000, 1'b0, 12'h020, 1'b0, 1'b0, 1'b1);
        send(12'h040, 12'h020, 1'b0, 12'h053, 1'b0, 1'b0, 1'b1);
      end
      begin
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        hold_z = out_z;
        repeat (5) begin
          @(negedge clk);
          chk("stall_hold_z", 32'(out_z), 32'(hold_z));
          chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk($sformatf("no_gap%0d", i), 32'(out_valid), 32'd1);
        end
      end
    join
    drain();

    // Reset with two ops in flight
    send(12'h040, 12'h020, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    send(12'h020, 12'h040, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_z", 32'(out_z), 32'h400);
    chk("mid_rst_ovf", 32'(out_ovf), 32'd0);
    chk("mid_rst_zero", 32'(out_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_ghost%0d", i), 32'(out_valid), 32'd0);
    end
    send(12'h040, 12'h020, 1'b1, 12'h020, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("post_rst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("post_rst_lat2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("post_rst_lat3", 32'(out_valid), 32'd1);
    drain();

`ifdef LNS_SAT_CNT_EN
    chk("sat_cnt", 32'(sat_cnt), 32'(exp_sat));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
